// File: rtl/gg_bytestream_pkg.sv
// Shared constants and FSM state encoding for the Annex-B byte-stream packer.
package gg_bytestream_pkg;

    localparam int PAD_BYTES = 4;

    typedef enum logic [1:0] {
        PK_FILL,
        PK_EMIT,
        PK_FLUSH
    } pk_state_t;

    localparam logic [7:0] EPB_BYTE  = 8'h03;
    localparam logic [7:0] ZERO_BYTE = 8'h00;

endpackage

// File: rtl/gg_bytestream_packer_if.sv
// Byte-in / word-out bundle of the packer; master is the stream source and word sink.
interface gg_bytestream_packer_if
    import gg_bytestream_pkg::*;
#(
    parameter int WID = 128
);
    localparam int BYTE_WID = WID / 8;

    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [WID-1:0]         out_bits;
    logic [8*PAD_BYTES-1:0] out_pad;
    logic [BYTE_WID-1:0]    out_nal_start;
    logic                   out_last;
    logic [15:0]            epb_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_bits, out_pad, out_nal_start, out_last, epb_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_bits, out_pad, out_nal_start, out_last, epb_count
    );

endinterface

// File: rtl/gg_epb_strip.sv
// Emulation-prevention detector: flags a 0x03 that follows two zero bytes and
// keeps the saturating zero-run length across accepted bytes.
module gg_epb_strip
    import gg_bytestream_pkg::*;
#(
    parameter bit EPB_STRIP = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       byte_en,
    input  logic       clear,
    input  logic [7:0] byte_in,
    output logic       keep
);

    logic [1:0] zrun_reg;
    logic [1:0] zrun_next;
    logic       drop;

    assign drop = EPB_STRIP && (zrun_reg == 2'd2) && (byte_in == EPB_BYTE);
    assign keep = !drop;

    always_comb begin
        zrun_next = zrun_reg;
        if (clear) begin
            zrun_next = 2'd0;
        end else if (byte_en) begin
            if (drop) begin
                zrun_next = 2'd0;
            end else if (byte_in == ZERO_BYTE) begin
                zrun_next = (zrun_reg == 2'd2) ? 2'd2 : zrun_reg + 2'd1;
            end else begin
                zrun_next = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zrun_reg <= 2'd0;
        end else begin
            zrun_reg <= zrun_next;
        end
    end

endmodule

// File: rtl/gg_bytestream_packer.sv
// Packs an Annex-B byte stream (EPBs optionally stripped) into WID-bit big-endian
// words, each carrying the next four stream bytes as lookahead.
module gg_bytestream_packer
    import gg_bytestream_pkg::*;
#(
    parameter int WID       = 128,
    parameter bit EPB_STRIP = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    gg_bytestream_packer_if.slave  bus
);

    localparam int BYTE_WID = WID / 8;
    localparam int DEPTH    = BYTE_WID + PAD_BYTES;
    localparam int CW       = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BW_C    = CW'(BYTE_WID);
    localparam logic [CW-1:0] PAD_C   = CW'(PAD_BYTES);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    pk_state_t      state_reg, state_next;
    logic [7:0]     buf_reg [DEPTH];
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           first_reg, first_next;
    logic           run_reg;
    logic           clr_pend_reg, clr_pend_next;
    logic [15:0]    epb_reg, epb_next;

    logic                   in_ready;
    logic                   out_valid;
    logic                   out_last;
    logic                   in_fire;
    logic                   out_fire;
    logic                   flush_done;
    logic                   shift;
    logic                   keep;
    logic [WID-1:0]         out_bits_w;
    logic [8*PAD_BYTES-1:0] out_pad_w;

    gg_epb_strip #(
        .EPB_STRIP (EPB_STRIP)
    ) u_epb (
        .clk     (clk),
        .reset_n (reset_n),
        .byte_en (in_fire),
        .clear   (flush_done),
        .byte_in (bus.in_data),
        .keep    (keep)
    );

    // run_reg holds in_ready low until the first edge after reset release.
    assign in_ready   = run_reg && (state_reg == PK_FILL) && (cnt_reg < DEPTH_C);
    assign out_valid  = (state_reg != PK_FILL);
    assign out_last   = (state_reg == PK_FLUSH) && (cnt_reg <= BW_C);
    assign in_fire    = bus.in_valid && in_ready;
    assign out_fire   = out_valid && bus.out_ready;
    assign flush_done = out_fire && out_last;
    assign shift      = out_fire && !out_last;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        first_next = first_reg;
        case (state_reg)
            PK_FILL: begin
                if (in_fire) begin
                    if (keep) begin
                        cnt_next = cnt_reg + ONE_C;
                    end
                    // A final byte always flushes, even when it is a dropped EPB.
                    if (bus.in_last) begin
                        state_next = PK_FLUSH;
                    end else if (keep && (cnt_reg == DEPTH_C - ONE_C)) begin
                        state_next = PK_EMIT;
                    end
                end
            end
            PK_EMIT: begin
                if (out_fire) begin
                    cnt_next   = PAD_C;
                    first_next = 1'b0;
                    state_next = PK_FILL;
                end
            end
            PK_FLUSH: begin
                if (out_fire) begin
                    if (out_last) begin
                        cnt_next   = '0;
                        first_next = 1'b1;
                        state_next = PK_FILL;
                    end else begin
                        cnt_next   = cnt_reg - BW_C;
                        first_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = PK_FILL;
            end
        endcase
    end

    // The count of the finished stream stays visible until the next stream's first byte.
    always_comb begin
        epb_next      = epb_reg;
        clr_pend_next = clr_pend_reg;
        if (flush_done) begin
            clr_pend_next = 1'b1;
        end else if (in_fire) begin
            clr_pend_next = 1'b0;
            if (clr_pend_reg) begin
                epb_next = keep ? 16'd0 : 16'd1;
            end else if (!keep && (epb_reg != 16'hFFFF)) begin
                epb_next = epb_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= PK_FILL;
            cnt_reg      <= '0;
            first_reg    <= 1'b1;
            run_reg      <= 1'b0;
            clr_pend_reg <= 1'b0;
            epb_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            first_reg    <= first_next;
            run_reg      <= 1'b1;
            clr_pend_reg <= clr_pend_next;
            epb_reg      <= epb_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_reg[i] <= '0;
            end
        end else if (in_fire && keep) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == cnt_reg) begin
                    buf_reg[i] <= bus.in_data;
                end
            end
        end else if (shift) begin
            for (int i = 0; i < DEPTH - BYTE_WID; i++) begin
                buf_reg[i] <= buf_reg[i + BYTE_WID];
            end
        end
    end

    // Lanes at or beyond the fill count read as zero, which pads the tail of a flush.
    for (genvar gi = 0; gi < BYTE_WID; gi++) begin : g_bits
        assign out_bits_w[WID-1-8*gi -: 8] =
            (out_valid && (CW'(gi) < cnt_reg)) ? buf_reg[gi] : ZERO_BYTE;
    end

    for (genvar gi = 0; gi < PAD_BYTES; gi++) begin : g_pad
        assign out_pad_w[8*PAD_BYTES-1-8*gi -: 8] =
            (out_valid && (CW'(BYTE_WID + gi) < cnt_reg)) ? buf_reg[BYTE_WID + gi] : ZERO_BYTE;
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_last      = out_last;
    assign bus.out_bits      = out_bits_w;
    assign bus.out_pad       = out_pad_w;
    assign bus.out_nal_start = (out_valid && first_reg) ? {1'b1, {(BYTE_WID-1){1'b0}}} : '0;
    assign bus.epb_count     = epb_reg;

endmodule

// File: tb/tb_gg_bytestream_packer.sv
// Bench for gg_bytestream_packer: stripping and non-stripping instances, a word
// scoreboard fed by a stream model, and hand-built stall/reset sequences.
module tb_gg_bytestream_packer;

    typedef logic [7:0] byte_q_t[$];

    typedef struct packed {
        logic [127:0] bits;
        logic [31:0]  pad;
        logic [15:0]  nal;
        logic         last;
        logic         chk_epb;
        logic [15:0]  epb;
    } exp_t;

    typedef struct {
        string hex;
        bit    sel;
        int    epb;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    vec_t vt[8];

    gg_bytestream_packer_if #(.WID(128)) if_a ();
    gg_bytestream_packer_if #(.WID(128)) if_b ();

    gg_bytestream_packer #(.WID(128), .EPB_STRIP(1'b1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    gg_bytestream_packer #(.WID(128), .EPB_STRIP(1'b0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit sel, input logic v, input logic [7:0] d, input logic l);
        if (sel) begin
            if_b.in_valid = v; if_b.in_data = d; if_b.in_last = l;
        end else begin
            if_a.in_valid = v; if_a.in_data = d; if_a.in_last = l;
        end
    endtask

    task automatic set_ordy(input bit sel, input logic r);
        if (sel) if_b.out_ready = r;
        else     if_a.out_ready = r;
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? if_b.in_ready : if_a.in_ready;
    endfunction

    function automatic logic get_ovalid(input bit sel);
        return sel ? if_b.out_valid : if_a.out_valid;
    endfunction

    function automatic int hexval(input byte c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return int'(c) - 55;
    endfunction

    function automatic byte_q_t hex2q(input string s);
        byte_q_t q;
        for (int i = 0; i + 1 < s.len(); i += 2) begin
            q.push_back(8'(hexval(s[i]) * 16 + hexval(s[i+1])));
        end
        return q;
    endfunction

    // Stream model: strip EPBs, then cut the kept bytes into 16-byte words with 4-byte lookahead.
    task automatic model_push(input byte_q_t q, input bit sel, input int exp_epb);
        byte_q_t k;
        int z = 0;
        int drops = 0;
        int nw;
        exp_t e;
        foreach (q[i]) begin
            if (!sel && z == 2 && q[i] == 8'h03) begin
                drops++;
                z = 0;
            end else begin
                k.push_back(q[i]);
                z = (q[i] == 8'h00) ? ((z < 2) ? z + 1 : 2) : 0;
            end
        end
        nw = (k.size() + 15) / 16;
        if (nw == 0) nw = 1;
        for (int w = 0; w < nw; w++) begin
            e = '0;
            for (int j = 0; j < 16; j++)
                if (16*w + j < k.size()) e.bits[127-8*j -: 8] = k[16*w + j];
            for (int j = 0; j < 4; j++)
                if (16*w + 16 + j < k.size()) e.pad[31-8*j -: 8] = k[16*w + 16 + j];
            e.nal     = (w == 0) ? 16'h8000 : 16'h0000;
            e.last    = (w == nw - 1);
            e.chk_epb = e.last;
            e.epb     = 16'((exp_epb < 0) ? drops : exp_epb);
            sb.push_back(e);
        end
    endtask

    task automatic check_word(input bit sel);
        exp_t e;
        logic [127:0] bits;
        logic [31:0]  pad;
        logic [15:0]  nal;
        logic [15:0]  epb;
        logic         last;
        if (sel) begin
            bits = if_b.out_bits; pad = if_b.out_pad; nal = if_b.out_nal_start;
            last = if_b.out_last; epb = if_b.epb_count;
        end else begin
            bits = if_a.out_bits; pad = if_a.out_pad; nal = if_a.out_nal_start;
            last = if_a.out_last; epb = if_a.epb_count;
        end
        $display("word dut=%0d bits=%h pad=%h nal=%h last=%0d epb=%0d", sel, bits, pad, nal, last, epb);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got %h, expected no word", bits);
            return;
        end
        e = sb.pop_front();
        chk("out_bits", bits, e.bits);
        chk("out_pad", pad, e.pad);
        chk("out_nal_start", nal, e.nal);
        chk("out_last", last, e.last);
        if (e.chk_epb) chk("epb_count", epb, e.epb);
    endtask

    // Called on a negedge; inputs and out_ready are decided here for the next posedge.
    task automatic drive(input byte_q_t q, input int start, input bit sel, input bit rnd);
        int idx = start;
        int t = 0;
        bit go;
        bit ordy;
        while ((idx < q.size() || sb.size() != 0) && t < 4000) begin
            go   = !rnd || ($urandom_range(3) != 0);
            ordy = !rnd || ($urandom_range(3) != 0);
            set_ordy(sel, ordy);
            if (idx < q.size() && go) begin
                set_in(sel, 1'b1, q[idx], idx == q.size() - 1);
                if (get_ready(sel)) idx++;
            end else begin
                set_in(sel, 1'b0, 8'($urandom), 1'($urandom));
            end
            if (get_ovalid(sel) && ordy) check_word(sel);
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            n_checks++;
            n_errors++;
            $display("FAIL drive_timeout: got %0d words pending, expected 0", sb.size());
            sb.delete();
        end
        set_in(sel, 1'b0, 8'h00, 1'b0);
        set_ordy(sel, 1'b1);
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] d, input logic l);
        int t = 0;
        set_in(sel, 1'b1, d, l);
        while (!get_ready(sel) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0, expected 1");
        end
        @(negedge clk);
        set_in(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_in_ready"}, if_a.in_ready, 1'b0);
        chk({tag, "_out_valid"}, if_a.out_valid, 1'b0);
        chk({tag, "_out_bits"}, if_a.out_bits, 128'h0);
        chk({tag, "_out_pad"}, if_a.out_pad, 32'h0);
        chk({tag, "_nal_start"}, if_a.out_nal_start, 16'h0);
        chk({tag, "_out_last"}, if_a.out_last, 1'b0);
        chk({tag, "_epb_count"}, if_a.epb_count, 16'h0);
    endtask

    initial begin
        byte_q_t q;
        exp_t    e;
        int      len;
        int      t;

        vt[0] = '{"1122000003013344", 1'b0, 1};
        vt[1] = '{"1122000003013344", 1'b1, 0};
        vt[2] = '{"0000000355", 1'b0, 1};
        vt[3] = '{"aa000355", 1'b0, 0};
        vt[4] = '{"00112233445566778899aabbccddeeff", 1'b0, 0};
        vt[5] = '{"0102030405060708090a0b0c0d0e000003", 1'b0, 1};
        vt[6] = '{"000003010000030100000301000003010000030100000301000003010000030100000301", 1'b0, 9};
        vt[7] = '{"0000000355", 1'b1, 0};

        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        set_ordy(1'b0, 1'b1);
        set_ordy(1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check_reset_a("reset");
        chk("reset_in_ready_b", if_b.in_ready, 1'b0);
        reset_n = 1'b1;
        #1;
        chk("ready_at_release", if_a.in_ready, 1'b0);
        @(negedge clk);
        chk("ready_after_reset", if_a.in_ready, 1'b1);

        // SPS example with literal expectations.
        q = hex2q("000000012742e02af71626200000000000000001");
        e = '0;
        e.bits = 128'h00000001_2742e02a_f7162620_00000000;
        e.pad  = 32'h00000001;
        e.nal  = 16'h8000;
        sb.push_back(e);
        e = '0;
        e.bits    = 128'h00000001_00000000_00000000_00000000;
        e.last    = 1'b1;
        e.chk_epb = 1'b1;
        sb.push_back(e);
        drive(q, 0, 1'b0, 1'b0);

        foreach (vt[v]) begin
            q = hex2q(vt[v].hex);
            model_push(q, vt[v].sel, vt[v].epb);
            drive(q, 0, vt[v].sel, 1'b0);
        end

        // Back-pressure in EMIT: word and lookahead must hold, input must stay blocked.
        q.delete();
        for (int i = 0; i < 24; i++) q.push_back(8'(8'h40 + i));
        model_push(q, 1'b0, 0);
        set_ordy(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(1'b0, q[i], 1'b0);
        chk("emit_latency", if_a.out_valid, 1'b1);
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", if_a.out_valid, 1'b1);
            chk("stall_bits", if_a.out_bits, sb[0].bits);
            chk("stall_pad", if_a.out_pad, sb[0].pad);
            chk("stall_in_ready", if_a.in_ready, 1'b0);
            @(negedge clk);
        end
        set_ordy(1'b0, 1'b1);
        check_word(1'b0);
        @(negedge clk);
        chk("post_fire_valid", if_a.out_valid, 1'b0);
        chk("post_fire_ready", if_a.in_ready, 1'b1);
        drive(q, 20, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 45);
            q.delete();
            for (int i = 0; i < len; i++)
                q.push_back(($urandom_range(1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
            model_push(q, 1'(r % 2), -1);
            drive(q, 0, 1'(r % 2), 1'b1);
        end

        // Asynchronous reset in the middle of a word discards it.
        q = hex2q("00000311223344");
        foreach (q[i]) send_byte(1'b0, q[i], 1'b0);
        chk("epb_before_reset", if_a.epb_count, 16'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_a("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        t = 0;
        while (!if_a.in_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        q = hex2q("0000000167640028acd2000000010000000168ee");
        model_push(q, 1'b0, -1);
        drive(q, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
